// File: rtl/countdown_timer.sv
// MM:SS.cc kitchen-timer datapath: loads a BCD preset, counts down every TICK_DIV
// clocks while running, and flags expiry at 00:00.00 using the stopwatch digit layout.
module countdown_timer #(
    parameter int TICK_DIV = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        start_stop,
    input  logic [23:0] preset,
    output logic [3:0]  r0,
    output logic [3:0]  r1,
    output logic [3:0]  r2,
    output logic [3:0]  r3,
    output logic [3:0]  r4,
    output logic [3:0]  r5,
    output logic        running,
    output logic        expired,
    output logic        done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PAUSED,
        RUNNING,
        EXPIRED
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [PW-1:0]    prescaler;
    logic [5:0][3:0]  digits;
    logic [5:0][3:0]  clamped;
    logic [5:0][3:0]  decremented;
    logic             borrow;
    logic             tick;

    assign tick = (state == RUNNING) && (prescaler == PW'(TICK_DIV - 1));

    // Digit index 3 is seconds-tens, the only digit whose range tops out at 5.
    always_comb begin
        clamped = '0;
        for (int i = 0; i < 6; i++) begin
            clamped[i] = preset[4*i +: 4];
            if (i == 3) begin
                if (clamped[i] > 4'd5) clamped[i] = 4'd5;
            end else if (clamped[i] > 4'd9) begin
                clamped[i] = 4'd9;
            end
        end
    end

    always_comb begin
        decremented = digits;
        borrow      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (digits[i] == 4'd0) begin
                    decremented[i] = (i == 3) ? 4'd5 : 4'd9;
                end else begin
                    decremented[i] = digits[i] - 4'd1;
                    borrow         = 1'b0;
                end
            end
        end
    end

    // Reaching zero on a tick wins over a simultaneous pause request.
    always_comb begin
        next_state = state;
        if (load) begin
            next_state = (clamped != '0) ? PAUSED : IDLE;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                PAUSED:  if (start_stop) next_state = RUNNING;
                RUNNING: begin
                    if (tick && decremented == '0) next_state = EXPIRED;
                    else if (start_stop)           next_state = PAUSED;
                end
                EXPIRED: if (start_stop) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prescaler <= '0;
            digits    <= '0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (next_state == EXPIRED) && (state != EXPIRED);
            if (state == RUNNING && next_state == RUNNING && !tick)
                prescaler <= prescaler + PW'(1);
            else
                prescaler <= '0;
            if (load)
                digits <= clamped;
            else if (tick)
                digits <= decremented;
        end
    end

    assign r0      = digits[0];
    assign r1      = digits[1];
    assign r2      = digits[2];
    assign r3      = digits[3];
    assign r4      = digits[4];
    assign r5      = digits[5];
    assign running = (state == RUNNING);
    assign expired = (state == EXPIRED);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Count-down counterpart to the stopwatch datapath: holds a loaded MM:SS.cc preset and decrements it every 10 ms while running.
- Flags expiry when the value reaches 00:00.00.
- Digit outputs use the stopwatch's BCD layout, so the existing 4-bit seven-segment encoders display them without change.
- Sits between the debounced key pulses and the encoders; replaces the stopwatch counter chain in the kitchen-timer build.

Parameters:
- TICK_DIV, 500000, clk cycles per decrement (10 ms at 50 MHz); the bench uses 4.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle pulse; copy preset into the digit registers
- start_stop  in  1  single-cycle pulse; run/pause toggle, or expiry acknowledge
- preset  in  24  BCD value {r5,r4,r3,r2,r1,r0}, 4 bits per digit
- r0  out  4  hundredths units (0-9)
- r1  out  4  hundredths tens (0-9)
- r2  out  4  seconds units (0-9)
- r3  out  4  seconds tens (0-5)
- r4  out  4  minutes units (0-9)
- r5  out  4  minutes tens (0-9)
- running  out  1  high in RUNNING
- expired  out  1  high in EXPIRED
- done  out  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous and active-low.
- Reset (asserted, takes effect immediately):
  - state = IDLE;
  - r0..r5 = 0; running, expired, done = 0;
  - prescaler = 0.
- States: IDLE, PAUSED, RUNNING, EXPIRED.
- load, any state:
  - digits <= clamped preset on the next edge;
  - state <= PAUSED if the clamped value is nonzero, else IDLE;
  - prescaler cleared.
  - load has priority over start_stop in the same cycle.
- Clamp rule: any preset digit > 9 loads as 9. r3 > 5 loads as 5.
- start_stop, no load in the same cycle:
  - IDLE: ignored.
  - PAUSED -> RUNNING.
  - RUNNING -> PAUSED.
  - EXPIRED -> IDLE; expired drops the next cycle.
- Prescaler:
  - counts 0..TICK_DIV-1 only in RUNNING;
  - forced to 0 in every other state, so pausing discards the partial tick;
  - tick = RUNNING && prescaler == TICK_DIV-1; prescaler wraps to 0 on tick.
  - First decrement after start: exactly TICK_DIV cycles after the start_stop edge.
- Decrement on tick, borrow chain from r0 upward:
  - a digit at 0 wraps to 9 (r3 wraps to 5) and borrows from the next digit;
  - a nonzero digit decrements and stops the chain;
  - r5 never underflows, because RUNNING implies a nonzero value.
- Expiry:
  - if the post-decrement value is 000000, state <= EXPIRED on that same edge;
  - done = 1 for exactly that following cycle;
  - expired stays high until acknowledged or load/reset.
- Output timing:
  - digits, running and expired are registered; they update on the edge after the causing event;
  - no combinational path from the inputs to the outputs.
- Digits hold their value in IDLE, PAUSED and EXPIRED.
- A tick and start_stop in the same RUNNING cycle: the decrement is applied and the state goes to PAUSED.

Test Plan (TICK_DIV=4):
- Reset: pulse reset_n low mid-cycle -> outputs zero immediately (asynchronous); state IDLE; start_stop is then ignored (running stays 0).
- Borrow chain: preset 24'h000102, load, start_stop -> display 00:01.01 at +4 cycles, 00:01.00 at +8, 00:00.99 at +12; running = 1 throughout.
- Wide borrow: preset 24'h100000, run one tick -> r5..r0 = 0,9,5,9,9,9.
- Expiry:
  - preset 24'h000002, run 8 cycles -> digits 000000; expired = 1; done high exactly one cycle; running = 0;
  - start_stop -> expired = 0, state IDLE.
- Pause:
  - run 6 cycles (one decrement), pulse start_stop, wait 40 cycles -> digits unchanged;
  - resume -> next decrement exactly 4 cycles after resume.
- Clamp and priority: while RUNNING, drive load and start_stop together with preset 24'h007A0C -> digits 00:59.09; state PAUSED; running = 0.
